// File: rtl/chan_link_ctrl_if.sv
// chan_link_ctrl_if: source-side and sink-side valid/ready handshakes of chan_link_ctrl.
// master = source/sink environment, slave = controller.
interface chan_link_ctrl_if;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned ERR_W  = 5;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ERR_W-1:0]  out_err_bits;
  logic              out_timeout;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err_bits, out_timeout
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err_bits, out_timeout
  );
endinterface

// File: rtl/chan_link_ctrl.sv
// chan_link_ctrl: sequences one word through tx -> AWGN channel -> rx and keeps bit-error stats.
// Optional macro CHAN_LOOPBACK_EN adds lpbk_en, which bypasses the channel and samples tx_data.
module chan_link_ctrl #(
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  chan_link_ctrl_if.slave  link,
  output logic [23:0]      tx_data,
  output logic             awgn_start,
  input  logic             awgn_busy,
  input  logic [23:0]      rx_data,
  input  logic             clr_stats,
  output logic [31:0]      word_cnt,
  output logic [31:0]      bit_err_cnt,
  output logic             timeout_flag
`ifdef CHAN_LOOPBACK_EN
  ,
  input  logic             lpbk_en
`endif
);

  localparam int unsigned DATA_W = 24;
  localparam int unsigned ERR_W  = 5;
  localparam int unsigned STAT_W = 32;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_NOISE,
    S_SETTLE,
    S_CAPTURE,
    S_DELIVER
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  cnt;
  logic              abort;
  logic              lpbk_q;
  logic              lpbk_in_c;
  logic              accept_c;
  logic              timeout_c;
  logic [DATA_W-1:0] sample_c;
  logic [ERR_W-1:0]  err_c;
  logic [STAT_W:0]   bit_sum_c;

  function automatic logic [ERR_W-1:0] popcnt(input logic [DATA_W-1:0] v);
    logic [ERR_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(DATA_W); i++) n = n + ERR_W'(v[i]);
    return n;
  endfunction

`ifdef CHAN_LOOPBACK_EN
  assign lpbk_in_c = lpbk_en;

  // Loopback choice is frozen for the whole word at acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        lpbk_q <= 1'b0;
    else if (accept_c) lpbk_q <= lpbk_en;
  end
`else
  assign lpbk_in_c = 1'b0;
  assign lpbk_q    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; busy is ignored on the first WAIT_NOISE cycle (cnt==0).
  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    timeout_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (link.in_valid) begin
          accept_c   = 1'b1;
          next_state = S_LAUNCH;
        end
      end
      S_LAUNCH:     next_state = lpbk_q ? S_SETTLE : S_WAIT_NOISE;
      S_WAIT_NOISE: begin
        if (!awgn_busy && (cnt != '0)) begin
          next_state = S_SETTLE;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_c  = 1'b1;
          next_state = S_CAPTURE;
        end
      end
      S_SETTLE: begin
        if (cnt == CNT_W'(SETTLE_CYCLES - 1)) next_state = S_CAPTURE;
      end
      S_CAPTURE:    next_state = S_DELIVER;
      S_DELIVER: begin
        if (link.out_ready) next_state = S_IDLE;
      end
      default:      next_state = S_IDLE;
    endcase
  end

  assign sample_c  = lpbk_q ? tx_data : rx_data;
  assign err_c     = popcnt(sample_c ^ tx_data);
  assign bit_sum_c = {1'b0, bit_err_cnt} + (STAT_W + 1)'(err_c);

  // Handshake outputs and cycle counter (cleared on every state change).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      link.in_ready  <= 1'b1;
      link.out_valid <= 1'b0;
      awgn_start     <= 1'b0;
      cnt            <= '0;
      abort          <= 1'b0;
      tx_data        <= '0;
    end else begin
      link.in_ready  <= (next_state == S_IDLE);
      link.out_valid <= (next_state == S_DELIVER);
      awgn_start     <= accept_c && !lpbk_in_c;
      cnt            <= (next_state != state) ? '0 : cnt + CNT_W'(1);
      if (state == S_LAUNCH) abort <= 1'b0;
      else if (timeout_c)    abort <= 1'b1;
      if (accept_c) tx_data <= link.in_data;
    end
  end

  // Result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      link.out_data     <= '0;
      link.out_err_bits <= '0;
      link.out_timeout  <= 1'b0;
    end else if (state == S_CAPTURE) begin
      link.out_data     <= sample_c;
      link.out_err_bits <= err_c;
      link.out_timeout  <= abort;
    end
  end

  // Statistics; clr_stats overrides a coincident capture update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt     <= '0;
      bit_err_cnt  <= '0;
      timeout_flag <= 1'b0;
    end else if (clr_stats) begin
      word_cnt     <= '0;
      bit_err_cnt  <= '0;
      timeout_flag <= 1'b0;
    end else if (state == S_CAPTURE) begin
      if (abort) begin
        timeout_flag <= 1'b1;
      end else begin
        if (word_cnt != '1) word_cnt <= word_cnt + STAT_W'(1);
        bit_err_cnt <= bit_sum_c[STAT_W] ? '1 : bit_sum_c[STAT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_chan_link_ctrl.sv
// tb_chan_link_ctrl: randomized and directed self-checking bench for chan_link_ctrl.
// Reference model derives latency, result and statistics from the word-level rules.
module tb_chan_link_ctrl;

  localparam int SETTLE = 2;
  localparam int TO     = 64;

  logic        clk;
  logic        reset;
  logic [23:0] tx_data;
  logic        awgn_start;
  logic        awgn_busy;
  logic [23:0] rx_data;
  logic        clr_stats;
  logic [31:0] word_cnt;
  logic [31:0] bit_err_cnt;
  logic        timeout_flag;
  logic        lpbk_en;

  chan_link_ctrl_if link ();

  chan_link_ctrl #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .link         (link),
    .tx_data      (tx_data),
    .awgn_start   (awgn_start),
    .awgn_busy    (awgn_busy),
    .rx_data      (rx_data),
    .clr_stats    (clr_stats),
    .word_cnt     (word_cnt),
    .bit_err_cnt  (bit_err_cnt),
    .timeout_flag (timeout_flag)
`ifdef CHAN_LOOPBACK_EN
    ,
    .lpbk_en      (lpbk_en)
`endif
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          busy_len;
  int          busy_left;
  int          n_starts;
  int          starts_before;
  logic [23:0] noise_mask;
  logic [31:0] m_words;
  logic [31:0] m_bits;
  logic        m_flag;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub AWGN generator: busy for busy_len cycles after each start pulse.
  always @(posedge clk or negedge reset) begin
    if (!reset)          busy_left <= 0;
    else if (awgn_start) busy_left <= busy_len;
    else if (busy_left > 0) busy_left <= busy_left - 1;
  end
  assign awgn_busy = (busy_left > 0);
  assign rx_data   = tx_data ^ noise_mask;

  always @(posedge clk) if (reset && awgn_start) n_starts <= n_starts + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [23:0] d, input bit lp);
    bit rdy;
    rdy = 1'b0;
    for (int i = 0; i < 200 && !rdy; i++) begin
      @(negedge clk);
      rdy = link.in_ready;
    end
    check_eq("in_ready_before_accept", 32'(rdy), 32'd1);
    link.in_valid = 1'b1;
    link.in_data  = d;
    lpbk_en       = lp;
    starts_before = n_starts;
    @(posedge clk);
    #1;
    link.in_valid = 1'b0;
    lpbk_en       = 1'b0;
  endtask

  // Wait for the result of a just-accepted word and check it against the model.
  task automatic collect(input logic [23:0] d, input logic [23:0] m, input int blen, input bit lp);
    int          lat;
    int          exp_lat;
    int          exp_err;
    bit          seen;
    bit          ab;
    logic [23:0] exp_data;
    ab       = !lp && (blen >= TO);
    exp_data = lp ? d : (d ^ m);
    exp_err  = lp ? 0 : $countones(m);
    if (lp)      exp_lat = 1 + SETTLE + 1;
    else if (ab) exp_lat = 1 + TO + 1;
    else         exp_lat = 1 + ((blen + 1 > 2) ? blen + 1 : 2) + SETTLE + 1;
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 400 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (link.out_valid) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check_eq("out_valid_seen", 32'(seen), 32'd1);
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("out_data", 32'(link.out_data), 32'(exp_data));
    check_eq("out_err_bits", 32'(link.out_err_bits), 32'(exp_err));
    check_eq("out_timeout", 32'(link.out_timeout), 32'(ab));
    check_eq("start_pulses", 32'(n_starts - starts_before), lp ? 32'd0 : 32'd1);
    if (ab) m_flag = 1'b1;
    else begin
      m_words = m_words + 1;
      m_bits  = m_bits + 32'(exp_err);
    end
    check_eq("word_cnt", word_cnt, m_words);
    check_eq("bit_err_cnt", bit_err_cnt, m_bits);
    check_eq("timeout_flag", 32'(timeout_flag), 32'(m_flag));
  endtask

  task automatic handshake();
    @(negedge clk);
    link.out_ready = 1'b1;
    @(posedge clk);
    #1;
    link.out_ready = 1'b0;
    check_eq("out_valid_drop", 32'(link.out_valid), 32'd0);
    check_eq("in_ready_after_hs", 32'(link.in_ready), 32'd1);
  endtask

  task automatic run_word(input logic [23:0] d, input logic [23:0] m, input int blen, input int hold);
    noise_mask = m;
    busy_len   = blen;
    accept(d, 1'b0);
    collect(d, m, blen, 1'b0);
    repeat (hold) @(posedge clk);
    handshake();
  endtask

  task automatic clear_stats();
    @(negedge clk);
    clr_stats = 1'b1;
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
    m_words = 0;
    m_bits  = 0;
    m_flag  = 1'b0;
    check_eq("clr_word_cnt", word_cnt, 32'd0);
    check_eq("clr_bit_err_cnt", bit_err_cnt, 32'd0);
    check_eq("clr_timeout_flag", 32'(timeout_flag), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] d;
    logic [23:0] m;
    int          blen;
    int          r;
    reset = 1'b0;
    link.in_valid  = 1'b0;
    link.in_data   = '0;
    link.out_ready = 1'b0;
    clr_stats  = 1'b0;
    lpbk_en    = 1'b0;
    noise_mask = '0;
    busy_len   = 0;
    n_starts   = 0;
    m_words    = 0;
    m_bits     = 0;
    m_flag     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_out_valid", 32'(link.out_valid), 32'd0);
    check_eq("rst_out_data", 32'(link.out_data), 32'd0);
    check_eq("rst_err_bits", 32'(link.out_err_bits), 32'd0);
    check_eq("rst_awgn_start", 32'(awgn_start), 32'd0);
    check_eq("rst_word_cnt", word_cnt, 32'd0);
    check_eq("rst_flag", 32'(timeout_flag), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(link.in_ready), 32'd1);

    // Clean word, then two words with a 3-bit error pattern.
    run_word(24'hA5A5A5, 24'h000000, 3, 0);
    clear_stats();
    run_word(24'h0000FF, 24'h000013, 3, 0);
    run_word(24'h0000FF, 24'h000013, 0, 1);

    // Generator stuck busy: abort on timeout, then clear the sticky flag.
    run_word(24'h3C3C3C, 24'h0F0000, 100000, 0);
    clear_stats();

    // Backpressure in DELIVER with a pending source word.
    noise_mask = 24'h800001;
    busy_len   = 1;
    accept(24'h111111, 1'b0);
    collect(24'h111111, 24'h800001, 1, 1'b0);
    @(negedge clk);
    link.in_valid = 1'b1;
    link.in_data  = 24'h222222;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_eq("hold_out_valid", 32'(link.out_valid), 32'd1);
      check_eq("hold_out_data", 32'(link.out_data), 32'h911110);
      check_eq("hold_in_ready", 32'(link.in_ready), 32'd0);
    end
    @(negedge clk);
    link.out_ready = 1'b1;
    @(posedge clk);
    #1;
    link.out_ready = 1'b0;
    check_eq("hs_out_valid", 32'(link.out_valid), 32'd0);
    check_eq("hs_tx_not_yet", 32'(tx_data), 32'h111111);
    starts_before = n_starts;
    @(posedge clk);
    #1;
    link.in_valid = 1'b0;
    check_eq("pending_accepted", 32'(tx_data), 32'h222222);
    collect(24'h222222, 24'h800001, 1, 1'b0);
    handshake();

    // Randomized words, including near and past the timeout boundary.
    for (int w = 0; w < 40; w++) begin
      d = 24'($urandom);
      r = int'($urandom_range(0, 9));
      m = (r < 3) ? 24'h0 : 24'($urandom);
      r = int'($urandom_range(0, 19));
      if (r == 0)      blen = TO + int'($urandom_range(0, 5));
      else if (r == 1) blen = TO - 1 - int'($urandom_range(0, 1));
      else             blen = int'($urandom_range(0, 6));
      run_word(d, m, blen, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 9) == 0) clear_stats();
    end

`ifdef CHAN_LOOPBACK_EN
    noise_mask = 24'h0F0F0F;
    busy_len   = 5;
    accept(24'h123456, 1'b1);
    collect(24'h123456, 24'h0F0F0F, 5, 1'b1);
    handshake();
`endif

    // Reset asserted mid-word while in SETTLE.
    run_word(24'h0A0B0C, 24'h000001, 0, 0);
    noise_mask = 24'h0;
    busy_len   = 0;
    accept(24'h5A5A5A, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 32'(link.out_valid), 32'd0);
    check_eq("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("mid_rst_word_cnt", word_cnt, 32'd0);
    check_eq("mid_rst_bit_err", bit_err_cnt, 32'd0);
    m_words = 0;
    m_bits  = 0;
    m_flag  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_in_ready", 32'(link.in_ready), 32'd1);
    check_eq("post_rst_word_cnt", word_cnt, 32'd0);
    run_word(24'hFFFFFF, 24'h0000F0, 2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
